// File: rtl/pwm_capture_if.sv
// Register bus shared by the PWM blocks.
// Master drives address/data/strobes; slave returns read data.
interface pwm_capture_if;
  logic [7:0] b_addr_i;
  logic [7:0] b_data_i;
  logic [7:0] b_data_o;
  logic [1:0] b_event_i;

  modport master (
    output b_addr_i,
    output b_data_i,
    output b_event_i,
    input  b_data_o
  );

  modport slave (
    input  b_addr_i,
    input  b_data_i,
    input  b_event_i,
    output b_data_o
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM decoder: measures high time and period of pwm_i in clocks.
// Results and flags are exposed on the 8-bit register bus.
module pwm_capture #(
  parameter int CNT_BITS = 16
) (
  input  logic         clk_i,
  input  logic         nrst_i,
  input  logic         pwm_i,
  pwm_capture_if.slave bus,
  output logic         irq_o
);
  localparam int HB = CNT_BITS - 8;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t              state;
  logic [CNT_BITS-1:0] cnt;
  logic [CNT_BITS-1:0] high_tmp;
  logic [CNT_BITS-1:0] high;
  logic [CNT_BITS-1:0] period;
  logic [HB-1:0]       high_sh;
  logic [HB-1:0]       period_sh;
  logic [7:0]          ctl0;
  logic                valid;
  logic                ovf;
  logic                s1;
  logic                s;
  logic                p;
  logic [7:0]          rdata;

  logic rise;
  logic fall;
  logic en;
  logic wr;
  logic rd;
  logic at_max;
  logic capture;
  logic ovf_evt;
  logic st_wr;

  assign rise    = s & ~p;
  assign fall    = ~s & p;
  assign en      = ctl0[7];
  assign wr      = bus.b_event_i[1];
  assign rd      = bus.b_event_i[0];
  assign st_wr   = wr && (bus.b_addr_i == 8'h01);
  assign at_max  = (cnt == '1);
  assign capture = en && (state == LOW) && rise;
  assign ovf_evt = en && at_max &&
                   (((state == HIGH) && !fall) ||
                    ((state == LOW) && !rise));

  // two-flop synchronizer plus a delay flop for edge detect
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      s1 <= 1'b0;
      s  <= 1'b0;
      p  <= 1'b0;
    end else begin
      s1 <= pwm_i;
      s  <= s1;
      p  <= s;
    end
  end

  // measurement FSM: count high phase, then whole period
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      high_tmp <= '0;
      high     <= '0;
      period   <= '0;
    end else if (!en) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rise) begin
            cnt   <= CNT_BITS'(1);
            state <= HIGH;
          end else begin
            cnt <= '0;
          end
        end
        HIGH: begin
          if (ovf_evt) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_BITS'(1);
            if (fall) begin
              high_tmp <= cnt;
              state    <= LOW;
            end
          end
        end
        LOW: begin
          if (capture) begin
            period <= cnt;
            high   <= high_tmp;
            cnt    <= CNT_BITS'(1);
            state  <= HIGH;
          end else if (ovf_evt) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_BITS'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // control, sticky flags (hardware set beats W1C) and hi shadows
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      ctl0      <= '0;
      valid     <= 1'b0;
      ovf       <= 1'b0;
      high_sh   <= '0;
      period_sh <= '0;
    end else begin
      if (wr && (bus.b_addr_i == 8'h00))
        ctl0 <= bus.b_data_i;
      if (capture)
        valid <= 1'b1;
      else if (st_wr && bus.b_data_i[0])
        valid <= 1'b0;
      if (ovf_evt)
        ovf <= 1'b1;
      else if (st_wr && bus.b_data_i[1])
        ovf <= 1'b0;
      if (rd && (bus.b_addr_i == 8'h02))
        high_sh <= high[CNT_BITS-1:8];
      if (rd && (bus.b_addr_i == 8'h04))
        period_sh <= period[CNT_BITS-1:8];
    end
  end

  // read mux
  always_comb begin
    rdata = 8'h00;
    case (bus.b_addr_i)
      8'h00:   rdata = ctl0;
      8'h01:   rdata = {5'b0, s, ovf, valid};
      8'h02:   rdata = high[7:0];
      8'h03:   rdata = 8'(high_sh);
      8'h04:   rdata = period[7:0];
      8'h05:   rdata = 8'(period_sh);
      default: rdata = 8'h00;
    endcase
  end

  assign bus.b_data_o = rdata;
  assign irq_o        = ctl0[6] & valid;
endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture.
// Reads queue expectations; a negedge monitor checks them.
module tb_pwm_capture;
  localparam int CB = 12;

  logic clk_i = 1'b0;
  logic nrst_i;
  logic pwm_i;
  logic irq_o;

  pwm_capture_if bus ();

  pwm_capture #(.CNT_BITS(CB)) dut (
    .clk_i  (clk_i),
    .nrst_i (nrst_i),
    .pwm_i  (pwm_i),
    .bus    (bus),
    .irq_o  (irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string      name;
    logic [7:0] addr;
    logic [7:0] exp;
    logic       exp_irq;
  } rd_t;

  rd_t q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  // reference model state, in specification terms
  logic [7:0] m_ctl = 8'h00;
  int         m_high = 0;
  int         m_period = 0;
  logic       m_valid = 1'b0;
  logic       m_ovf = 1'b0;
  logic       m_lvl = 1'b0;

  function automatic logic [7:0] hi(int v);
    return 8'((v >> 8) & ((1 << (CB - 8)) - 1));
  endfunction

  function automatic logic [7:0] st_exp();
    return {5'b0, m_lvl, m_ovf, m_valid};
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wr(logic [7:0] a, logic [7:0] d);
    bus.b_addr_i  = a;
    bus.b_data_i  = d;
    bus.b_event_i = 2'b10;
    step(1);
    bus.b_event_i = 2'b00;
  endtask

  task automatic rd(logic [7:0] a, logic [7:0] e, string nm);
    rd_t r;
    r.name    = nm;
    r.addr    = a;
    r.exp     = e;
    r.exp_irq = m_ctl[6] & m_valid;
    q.push_back(r);
    bus.b_addr_i  = a;
    bus.b_event_i = 2'b01;
    step(1);
    bus.b_event_i = 2'b00;
  endtask

  // n periods of h high / l low, then a rise that captures the last one
  task automatic run(int h, int l, int n);
    for (int i = 0; i < n; i++) begin
      pwm_i = 1'b1;
      step(h);
      pwm_i = 1'b0;
      step(l);
    end
    pwm_i = 1'b1;
    step(5);
    m_high   = h;
    m_period = h + l;
    m_valid  = 1'b1;
    m_lvl    = 1'b1;
  endtask

  task automatic chk_meas(string nm);
    rd(8'h02, 8'(m_high), {nm, "_hlo"});
    rd(8'h03, hi(m_high), {nm, "_hhi"});
    rd(8'h04, 8'(m_period), {nm, "_plo"});
    rd(8'h05, hi(m_period), {nm, "_phi"});
  endtask

  rd_t mr;

  // monitor: every read strobe consumes one expectation
  always @(negedge clk_i) begin
    if (nrst_i && bus.b_event_i[0]) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_read addr=%02h got=%02h exp=none",
                 bus.b_addr_i, bus.b_data_o);
      end else begin
        mr = q.pop_front();
        if (bus.b_data_o !== mr.exp) begin
          n_bad++;
          $display("FAIL %s addr=%02h got=%02h exp=%02h",
                   mr.name, mr.addr, bus.b_data_o, mr.exp);
        end
        n_cmp++;
        if (irq_o !== mr.exp_irq) begin
          n_bad++;
          $display("FAIL %s_irq got=%b exp=%b",
                   mr.name, irq_o, mr.exp_irq);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int h;
    int l;
    nrst_i        = 1'b0;
    pwm_i         = 1'b0;
    bus.b_addr_i  = 8'h00;
    bus.b_data_i  = 8'h00;
    bus.b_event_i = 2'b00;
    step(3);
    nrst_i = 1'b1;
    step(2);

    for (int a = 0; a < 6; a++)
      rd(8'(a), 8'h00, "reset");
    rd(8'h7F, 8'h00, "reset_unmapped");

    wr(8'h00, 8'hC0);
    m_ctl = 8'hC0;
    rd(8'h00, 8'hC0, "ctl0");
    run(30, 70, 3);
    rd(8'h01, st_exp(), "st_30_70");
    chk_meas("m30_70");

    run(300, 700, 2);
    rd(8'h04, 8'hE8, "p1000_lo");
    rd(8'h05, 8'h03, "p1000_hi");
    rd(8'h02, 8'h2C, "h300_lo");
    rd(8'h03, 8'h01, "h300_hi");
    wr(8'h01, 8'h01);
    m_valid = 1'b0;
    rd(8'h01, st_exp(), "st_w1c");

    step(4200);
    m_ovf = 1'b1;
    rd(8'h01, st_exp(), "st_ovf");
    rd(8'h02, 8'h2C, "ovf_hold_h");
    rd(8'h04, 8'hE8, "ovf_hold_p");
    pwm_i = 1'b0;
    m_lvl = 1'b0;
    step(50);
    run(40, 60, 2);
    rd(8'h01, st_exp(), "st_resume");
    chk_meas("resume");
    wr(8'h01, 8'h03);
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    rd(8'h01, st_exp(), "st_clr");

    run(1, 1, 4);
    rd(8'h01, st_exp(), "st_toggle");
    chk_meas("toggle");

    for (int k = 0; k < 6; k++) begin
      h = int'($urandom_range(1, 300));
      l = int'($urandom_range(1, 300));
      run(h, l, 2);
      rd(8'h01, st_exp(), "st_rand");
      chk_meas("rand");
    end

    wr(8'h01, 8'h01);
    m_valid = 1'b0;
    wr(8'h00, 8'h40);
    m_ctl = 8'h40;
    pwm_i = 1'b0;
    step(20);
    pwm_i = 1'b1;
    step(20);
    pwm_i = 1'b0;
    step(20);
    pwm_i = 1'b1;
    step(10);
    rd(8'h01, st_exp(), "st_disabled");
    chk_meas("disabled_hold");
    rd(8'h00, 8'h40, "ctl0_dis");

    wr(8'h00, 8'hC0);
    m_ctl = 8'hC0;
    run(25, 35, 2);
    rd(8'h01, st_exp(), "st_reen");
    chk_meas("reen");

    step(3);
    pwm_i = 1'b0;
    step(20);
    pwm_i = 1'b1;
    step(30);
    pwm_i = 1'b0;
    step(45);
    pwm_i = 1'b1;
    step(2);
    wr(8'h01, 8'h01);
    m_high   = 30;
    m_period = 75;
    m_valid  = 1'b1;
    step(3);
    rd(8'h01, st_exp(), "st_setwins");
    chk_meas("setwins");

    step(3);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pending_reads got=%0d exp=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
